// File: rtl/tpu_mem_pkg.sv
// Shared types and constants for the compute-side RAM stream reader.
package tpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int unsigned RD_LATENCY = 1;
    localparam int unsigned FIFO_DEPTH = 2;

    // A new read may go out only if everything already owed to the buffer still fits.
    function automatic logic window_open(input logic [1:0] count,
                                         input logic       ret,
                                         input logic       pop);
        logic [2:0] occ;
        occ = 3'(count) + 3'(ret) - 3'(pop);
        return occ < 3'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/single_port_ram_intf.sv
// Single-port RAM bank port; the compute side issues reads/writes, the RAM answers.
interface single_port_ram_intf #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  cs;
    logic                  oe;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  W_req;
    logic [DATA_WIDTH-1:0] W_data;
    logic [DATA_WIDTH-1:0] R_data;

    modport compute (
        output cs,
        output oe,
        output addr,
        output W_req,
        output W_data,
        input  R_data
    );

    modport ram (
        input  cs,
        input  oe,
        input  addr,
        input  W_req,
        input  W_data,
        output R_data
    );
endinterface

// File: rtl/stream_fifo2.sv
// Two-entry first-word-fall-through FIFO with flush; an empty FIFO passes a push straight to the output.
module stream_fifo2 #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] slots [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  empty;
    logic                  bypass;
    logic                  wr_en;
    logic                  rd_en;

    assign empty  = (count == 2'd0);
    assign bypass = empty && push && pop;
    assign wr_en  = push && !bypass;
    assign rd_en  = pop && !empty;

    // Output mux: stored head first, otherwise the word arriving this cycle.
    always_comb begin
        out_valid = !empty || push;
        out_data  = '0;
        if (!empty) begin
            out_data = slots[rd_ptr];
        end else if (push) begin
            out_data = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(wr_en) - 2'(rd_en);
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Read master: streams `length` consecutive RAM words from `base_addr` onto a valid/ready output.
module ram_stream_reader
    import tpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    single_port_ram_intf.compute  mem
);

    rd_state_e             state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [LEN_WIDTH-1:0]  issue_cnt;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [RD_LATENCY-1:0] inflight_q;
    logic                  ret;
    logic                  issue;
    logic                  flush;
    logic                  pop;
    logic [1:0]            buf_count;

    assign ret = inflight_q[RD_LATENCY-1];
    assign pop = out_valid && out_ready;

    // Issue gating; abort also suppresses the read of its own cycle.
    always_comb begin
        issue = 1'b0;
        flush = 1'b0;
        if (state != IDLE) begin
            flush = abort;
            issue = (state == READ) && !abort && (issue_cnt != '0) &&
                    window_open(buf_count, ret, pop);
        end
    end

    assign mem.cs     = issue;
    assign mem.oe     = issue;
    assign mem.addr   = rd_addr;
    assign mem.W_req  = 1'b0;
    assign mem.W_data = '0;

    stream_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (ret),
        .push_data (mem.R_data),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (buf_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_addr    <= '0;
            issue_cnt  <= '0;
            beat_cnt   <= '0;
            inflight_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            inflight_q <= RD_LATENCY'({inflight_q, issue});
            if (issue) begin
                rd_addr   <= rd_addr + ADDR_WIDTH'(1);
                issue_cnt <= issue_cnt - LEN_WIDTH'(1);
            end
            if (pop) begin
                beat_cnt <= beat_cnt - LEN_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr   <= base_addr;
                        issue_cnt <= length;
                        beat_cnt  <= length;
                        if (length != '0) begin
                            state <= READ;
                            busy  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        issue_cnt <= '0;
                        beat_cnt  <= '0;
                    end else if (issue && issue_cnt == LEN_WIDTH'(1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        issue_cnt <= '0;
                        beat_cnt  <= '0;
                    end else if (pop && beat_cnt == LEN_WIDTH'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
